// File: rtl/mo_pkg.sv
// Shared definitions for the motion-object fetch sequencer: shifter mode codes,
// sequencer states and pixels per ROM half.
package mo_pkg;

    localparam logic [1:0] SHFT_HOLD  = 2'b00;
    localparam logic [1:0] SHFT_LEFT  = 2'b01;
    localparam logic [1:0] SHFT_RIGHT = 2'b10;
    localparam logic [1:0] SHFT_LOAD  = 2'b11;

    localparam int PIX_PER_HALF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mo_fetch_sequencer.sv
// Per-pixel control sequencer for the motion-object picture ROM and pixel shifter:
// accepts object descriptors and plays out 8 pixel ticks (two 4-pixel ROM halves) each.
module mo_fetch_sequencer
    import mo_pkg::*;
#(
    parameter int XW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce5,
    input  logic          line_start,
    input  logic          obj_valid,
    output logic          obj_ready,
    input  logic [7:0]    obj_pic,
    input  logic [3:0]    obj_row,
    input  logic          obj_match,
    input  logic          obj_flip,
    input  logic [XW-1:0] obj_x,
    output logic          pic_ld,
    output logic [7:0]    pic_code,
    output logic [4:0]    addrlo,
    output logic          matchn,
    output logic          shft0,
    output logic          shft1,
    output logic          player2,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic          busy
);

    localparam logic [1:0] C_LAST = 2'(PIX_PER_HALF - 1);

    state_t        r_state, w_state_nxt;
    logic          r_h, w_h_nxt;
    logic [1:0]    r_c, w_c_nxt;
    logic [XW-1:0] r_x, w_x_nxt;
    logic          r_pic_ld, w_pic_ld_nxt;
    logic [7:0]    r_pic_code, w_pic_code_nxt;
    logic [4:0]    r_addrlo, w_addrlo_nxt;
    logic          r_matchn, w_matchn_nxt;
    logic [1:0]    r_shft, w_shft_nxt;
    logic          r_player2, w_player2_nxt;
    logic          r_pix_valid, w_pix_valid_nxt;
    logic [XW-1:0] r_pix_x, w_pix_x_nxt;
    logic          w_accept;

    // Ready only in IDLE or on the last pixel slot, so the next object overlaps tick 8.
    assign obj_ready = (r_state == IDLE) || (r_h && (r_c == C_LAST));
    assign w_accept  = ce5 && obj_valid && obj_ready && !line_start;

    always_comb begin
        w_state_nxt     = r_state;
        w_h_nxt         = r_h;
        w_c_nxt         = r_c;
        w_x_nxt         = r_x;
        w_pic_ld_nxt    = 1'b0;
        w_pic_code_nxt  = r_pic_code;
        w_addrlo_nxt    = r_addrlo;
        w_matchn_nxt    = r_matchn;
        w_shft_nxt      = r_shft;
        w_player2_nxt   = r_player2;
        w_pix_valid_nxt = r_pix_valid;
        w_pix_x_nxt     = r_pix_x;

        if (line_start) begin
            w_state_nxt     = IDLE;
            w_h_nxt         = 1'b0;
            w_c_nxt         = 2'd0;
            w_shft_nxt      = SHFT_HOLD;
            w_pix_valid_nxt = 1'b0;
            w_addrlo_nxt    = 5'd0;
            w_matchn_nxt    = 1'b1;
        end else if (ce5) begin
            if (r_state == RUN) begin
                // r_player2 still holds the running object's flip on an overlapping accept.
                if (r_c == 2'd0) w_shft_nxt = SHFT_LOAD;
                else             w_shft_nxt = r_player2 ? SHFT_RIGHT : SHFT_LEFT;
                w_pix_valid_nxt = 1'b1;
                w_pix_x_nxt     = (!r_h && r_c == 2'd0) ? r_x : r_pix_x + 1'b1;
                if (!r_h && r_c == 2'd1) w_addrlo_nxt[0] = 1'b1;
                w_c_nxt = r_c + 2'd1;
                if (r_c == C_LAST) begin
                    w_h_nxt = ~r_h;
                    if (r_h) w_state_nxt = IDLE;
                end
            end else begin
                w_shft_nxt      = SHFT_HOLD;
                w_pix_valid_nxt = 1'b0;
            end

            if (w_accept) begin
                w_pic_ld_nxt   = 1'b1;
                w_pic_code_nxt = obj_pic;
                w_addrlo_nxt   = {obj_row, 1'b0};
                w_matchn_nxt   = ~obj_match;
                w_player2_nxt  = obj_flip;
                w_x_nxt        = obj_x;
                w_state_nxt    = RUN;
                w_h_nxt        = 1'b0;
                w_c_nxt        = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_h         <= 1'b0;
            r_c         <= 2'd0;
            r_x         <= '0;
            r_pic_ld    <= 1'b0;
            r_pic_code  <= 8'd0;
            r_addrlo    <= 5'd0;
            r_matchn    <= 1'b1;
            r_shft      <= SHFT_HOLD;
            r_player2   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_h         <= w_h_nxt;
            r_c         <= w_c_nxt;
            r_x         <= w_x_nxt;
            r_pic_ld    <= w_pic_ld_nxt;
            r_pic_code  <= w_pic_code_nxt;
            r_addrlo    <= w_addrlo_nxt;
            r_matchn    <= w_matchn_nxt;
            r_shft      <= w_shft_nxt;
            r_player2   <= w_player2_nxt;
            r_pix_valid <= w_pix_valid_nxt;
            r_pix_x     <= w_pix_x_nxt;
        end
    end

    assign pic_ld    = r_pic_ld;
    assign pic_code  = r_pic_code;
    assign addrlo    = r_addrlo;
    assign matchn    = r_matchn;
    assign shft0     = r_shft[1];
    assign shft1     = r_shft[0];
    assign player2   = r_player2;
    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign busy      = (r_state != IDLE);

endmodule
